regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-side front end for the 32x32 register file: merges single-cycle ALU results
//  and long-latency load/mul-div results onto the file's single write port
//  (regWr/wrReg/wrData). Buffers long-latency results in a small FIFO, drops r0
//  writes, enforces WAW order, and reports pending writes to hazard logic.
// PARAMETERS
//  DEPTH      4   long-latency result FIFO entries (power of 2, >=2)
//  AW         5   register address width
//  DW         32  register data width
//  STARVE_MAX 8   consecutive ALU-won cycles with non-empty FIFO before aluStall fires
// PORTS
//  clk      in   1                clock, rising edge
//  rst_n    in   1                reset, asynchronous assert, active-low
//  aluWr    in   1                ALU result valid this cycle (no back-pressure)
//  aluReg   in   AW               ALU destination register
//  aluData  in   DW               ALU result
//  lsValid  in   1                long-latency result valid
//  lsReady  out  1                FIFO can accept; transfer when lsValid&&lsReady
//  lsReg    in   AW               long-latency destination register
//  lsData   in   DW               long-latency result
//  qReg1    in   AW               hazard query address 1
//  qReg2    in   AW               hazard query address 2
//  qHit1    out  1                live write to qReg1 pending (FIFO or output reg)
//  qHit2    out  1                same, for qReg2
//  aluStall out  1                registered; demands aluWr=0 next cycle so FIFO drains
//  regWr    out  1                to register file write enable
//  wrReg    out  AW               to register file write address
//  wrData   out  DW               to register file write data
//  qCount   out  $clog2(DEPTH+1)  FIFO occupancy (live and killed entries)
// BEHAVIOUR
//  Reset (async, rst_n=0): regWr=0, wrReg=0, wrData=0, FIFO empty, qCount=0,
//   aluStall=0, starve counter=0; lsReady=1 once reset is released.
//  lsReady = (qCount != DEPTH), combinational. No push while full, even with a pop.
//  Write-port select, evaluated per cycle:
//   1) aluWr && aluReg!=0: ALU wins.
//   2) else FIFO non-empty: pop head; if head is killed, pop with regWr=0 next cycle.
//   3) else lsValid accepted && lsReg!=0 && no kill: bypass FIFO, write directly.
//   4) else regWr=0 next cycle.
//  Winner is registered onto regWr/wrReg/wrData at the next posedge. The register
//  file commits on the posedge after that; latency is 1 cycle with bypass.
//  r0 writes: ALU r0 counts as no request. LS r0 is accepted (handshake completes)
//   and discarded; it is never enqueued.
//  WAW ordering: ALU writes are youngest. On aluWr to R!=0:
//   - every FIFO entry with reg==R gets its kill bit set;
//   - an LS entry to R accepted in the same cycle is enqueued already killed.
//  qHitN = output reg (regWr && wrReg==qRegN) OR any live FIFO entry matching qRegN.
//   qRegN==0 gives 0.
//  Starvation: the counter increments on each cycle where ALU wins and the FIFO is
//   non-empty, and clears on any pop or when the FIFO is empty. At STARVE_MAX it
//   clears and aluStall=1 for exactly one cycle. If aluWr is still asserted during
//   aluStall, the ALU still wins (protocol violation; assertion in bench).
//  Push and pop in the same cycle: occupancy stays constant; pointers wrap mod DEPTH.
// STRUCTURE
//  Shared package regfile_pkg: AW, DW, REG_ZERO=5'd0, wb_entry_t {reg, data, kill}.
//  Sub-module wb_fifo: DEPTH-entry circular buffer of wb_entry_t. Provides push/pop,
//   full/empty/count, a parallel kill-by-address port, and two live-match CAM ports
//   for qHit. Top level holds the select mux, output registers and starve counter.
// TESTING
//  Reset mid-traffic: FIFO 3 deep, drop rst_n -> regWr=0, qCount=0, lsReady=1
//   within the same cycle.
//  Bypass: idle; lsValid with lsReg=5, lsData=0xAA -> next edge regWr=1, wrReg=5,
//   wrData=0xAA, qCount stays 0.
//  Collision: aluWr r3=0x11 and ls r7=0x22 in the same cycle -> r3 written, then r7
//   on the following cycle; qCount goes 1 then 0.
//  WAW kill: ls r9=0x1 queued behind ALU traffic, then aluWr r9=0x2 -> final write
//   to r9 is 0x2; the killed pop produces a regWr=0 cycle; qHit on r9 drops after
//   the ALU write retires.
//  Full/r0: 4 ls pushes under continuous ALU writes -> lsReady=0 at qCount=4.
//   Ls r0 -> accepted, no write, qCount unchanged.
//  Starvation: continuous aluWr with FIFO non-empty -> aluStall pulses 1 cycle after
//   8 ALU wins; head pops in the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back front end.
package regfile_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          kill;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_fifo.sv
// Circular buffer of pending long-latency results with address kill and
// two live-match ports feeding the hazard query outputs.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_entry,
  input  logic                       i_pop,
  input  logic                       i_kill_en,
  input  logic [AW-1:0]              i_kill_reg,
  input  logic [AW-1:0]              i_q1,
  input  logic [AW-1:0]              i_q2,
  output wb_entry_t                  o_head,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_hit1,
  output logic                       o_hit2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  wb_entry_t        w_mem [DEPTH];
  logic [DEPTH-1:0] w_live;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = w_mem[r_rptr];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      wb_entry_t     r_entry;
      logic [PW-1:0] w_off;

      // Slot is live when its distance from the read pointer is below occupancy.
      assign w_off       = PW'(gi) - r_rptr;
      assign w_live[gi]  = (CW'(w_off) < r_count);
      assign w_mem[gi]   = r_entry;
      assign w_hit1[gi]  = w_live[gi] && !r_entry.kill && (r_entry.rd == i_q1);
      assign w_hit2[gi]  = w_live[gi] && !r_entry.kill && (r_entry.rd == i_q2);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_entry <= '0;
        end else if (w_push && (r_wptr == PW'(gi))) begin
          r_entry <= i_push_entry;
        end else if (i_kill_en && (r_entry.rd == i_kill_reg)) begin
          r_entry.kill <= 1'b1;
        end
      end
    end
  endgenerate

  assign o_hit1 = |w_hit1;
  assign o_hit2 = |w_hit2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port,
// keeping write-after-write order and starvation-limiting the ALU.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aluWr,
  input  logic [AW-1:0]              aluReg,
  input  logic [DW-1:0]              aluData,
  input  logic                       lsValid,
  output logic                       lsReady,
  input  logic [AW-1:0]              lsReg,
  input  logic [DW-1:0]              lsData,
  input  logic [AW-1:0]              qReg1,
  input  logic [AW-1:0]              qReg2,
  output logic                       qHit1,
  output logic                       qHit2,
  output logic                       aluStall,
  output logic                       regWr,
  output logic [AW-1:0]              wrReg,
  output logic [DW-1:0]              wrData,
  output logic [$clog2(DEPTH+1)-1:0] qCount
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic          r_regWr;
  logic [AW-1:0] r_wrReg;
  logic [DW-1:0] r_wrData;
  logic [SW-1:0] r_starve;
  logic          r_stall;

  logic          w_alu_req;
  logic          w_ls_acc;
  logic          w_kill_push;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_reg;
  logic [DW-1:0] w_sel_data;
  wb_entry_t     w_head;
  wb_entry_t     w_push_entry;
  logic          w_empty;
  logic          w_full;
  logic          w_fifo_hit1;
  logic          w_fifo_hit2;

  assign w_alu_req   = aluWr && (aluReg != REG_ZERO);
  assign lsReady     = !w_full;
  assign w_ls_acc    = lsValid && !w_full;
  assign w_kill_push = w_alu_req && (lsReg == aluReg);
  // r0 results complete the handshake but never enter the queue.
  assign w_push      = w_ls_acc && (lsReg != REG_ZERO) && !w_bypass;
  assign w_push_entry = '{rd: lsReg, data: lsData, kill: w_kill_push};

  always_comb begin
    w_pop      = 1'b0;
    w_bypass   = 1'b0;
    w_sel_wr   = 1'b0;
    w_sel_reg  = r_wrReg;
    w_sel_data = r_wrData;
    if (w_alu_req) begin
      w_sel_wr   = 1'b1;
      w_sel_reg  = aluReg;
      w_sel_data = aluData;
    end else if (!w_empty) begin
      w_pop      = 1'b1;
      w_sel_wr   = !w_head.kill;
      w_sel_reg  = w_head.rd;
      w_sel_data = w_head.data;
    end else if (w_ls_acc && (lsReg != REG_ZERO) && !w_kill_push) begin
      w_bypass   = 1'b1;
      w_sel_wr   = 1'b1;
      w_sel_reg  = lsReg;
      w_sel_data = lsData;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill_en    (w_alu_req),
    .i_kill_reg   (aluReg),
    .i_q1         (qReg1),
    .i_q2         (qReg2),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_count      (qCount),
    .o_hit1       (w_fifo_hit1),
    .o_hit2       (w_fifo_hit2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regWr  <= 1'b0;
      r_wrReg  <= '0;
      r_wrData <= '0;
    end else begin
      r_regWr  <= w_sel_wr;
      r_wrReg  <= w_sel_reg;
      r_wrData <= w_sel_data;
    end
  end

  // Counts ALU wins that left the queue waiting; any pop or empty queue resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_stall <= 1'b0;
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (w_alu_req) begin
        if (r_starve == SW'(STARVE_MAX - 1)) begin
          r_starve <= '0;
          r_stall  <= 1'b1;
        end else begin
          r_starve <= r_starve + SW'(1);
        end
      end
    end
  end

  assign regWr    = r_regWr;
  assign wrReg    = r_wrReg;
  assign wrData   = r_wrData;
  assign aluStall = r_stall;
  assign qHit1    = (qReg1 != REG_ZERO) && ((r_regWr && (r_wrReg == qReg1)) || w_fifo_hit1);
  assign qHit2    = (qReg2 != REG_ZERO) && ((r_regWr && (r_wrReg == qReg2)) || w_fifo_hit2);
endmodule
